// File: rtl/rcl_sched.sv
// rtl/rcl_sched.sv - round-robin scheduler sharing one circle/line relation engine among NREQ requesters
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake; req_ready is a one-hot grant
//   req_data               NREQ packets of 30 bits {m,a,n,b,k,c}, 5 bits each, packet i at [30*i+29:30*i]
//   eng_in_valid           engine beat strobe (registered)
//   eng_coef_Q/eng_coef_L  engine beat payload: (m,a), (n,b), (k,c) on three gapless beats
//   eng_out_valid/eng_out  engine result strobe and 2-bit relation
//   rsp_valid/rsp_id/rsp_out  one-cycle response tagged with the originating requester
//   busy                   packet in progress or results outstanding
//   err                    sticky: engine result arrived with no outstanding tag
module rcl_sched #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*30-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              eng_in_valid,
    output logic [4:0]        eng_coef_Q,
    output logic [4:0]        eng_coef_L,
    input  logic              eng_out_valid,
    input  logic [1:0]        eng_out,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [1:0]        rsp_out,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

    localparam logic [1:0] LAST_ID = 2'(NREQ - 1);

    state_t      state, state_nxt;
    logic [1:0]  rr_ptr;
    logic [1:0]  win;
    logic        win_found;
    logic        grant;
    logic        pop;
    logic        can_push;
    logic [29:0] pkt_sel;
    logic [19:0] hold;        // n, b, k, c; m and a go straight out on the first beat
    logic [1:0]  fifo [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    // Round-robin search starting one past the last winner.
    always_comb begin
        int         cand;
        logic [1:0] cidx;
        win       = '0;
        win_found = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(rr_ptr) + off) % NREQ;
            cidx = 2'(cand);
            if (!win_found && req_valid[cidx]) begin
                win_found = 1'b1;
                win       = cidx;
            end
        end
    end

    always_comb begin
        pkt_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == 2'(i)) begin
                pkt_sel = req_data[30*i +: 30];
            end
        end
    end

    assign pop      = eng_out_valid && (count != 2'd0);
    // A pop in the same cycle frees the slot the new tag needs.
    assign can_push = (count < 2'd2) || pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        req_ready = '0;
        case (state)
            IDLE, B2: begin
                state_nxt = IDLE;
                if (win_found && can_push) begin
                    grant          = 1'b1;
                    req_ready[win] = 1'b1;
                    state_nxt      = B0;
                end
            end
            B0:      state_nxt = B1;
            B1:      state_nxt = B2;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= LAST_ID;
            hold         <= '0;
            fifo[0]      <= '0;
            fifo[1]      <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= '0;
            eng_in_valid <= 1'b0;
            eng_coef_Q   <= '0;
            eng_coef_L   <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_out      <= '0;
            err          <= 1'b0;
        end else begin
            if (grant) begin
                rr_ptr       <= win;
                hold         <= pkt_sel[19:0];
                fifo[wr_ptr] <= win;
                wr_ptr       <= ~wr_ptr;
            end

            case ({grant, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            rsp_valid <= pop;
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                rsp_id  <= fifo[rd_ptr];
                rsp_out <= eng_out;
            end

            if (eng_out_valid && (count == 2'd0)) begin
                err <= 1'b1;
            end

            // Beat registers are loaded from the state being entered so the first
            // beat appears the cycle after the handshake.
            case (state_nxt)
                B0: begin
                    eng_in_valid <= 1'b1;
                    eng_coef_Q   <= pkt_sel[29:25];
                    eng_coef_L   <= pkt_sel[24:20];
                end
                B1: begin
                    eng_in_valid <= 1'b1;
                    eng_coef_Q   <= hold[19:15];
                    eng_coef_L   <= hold[14:10];
                end
                B2: begin
                    eng_in_valid <= 1'b1;
                    eng_coef_Q   <= hold[9:5];
                    eng_coef_L   <= hold[4:0];
                end
                default: begin
                    eng_in_valid <= 1'b0;
                    eng_coef_Q   <= '0;
                    eng_coef_L   <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE) || (count != 2'd0);

endmodule

// File: tb/tb_rcl_sched.sv
// tb/tb_rcl_sched.sv - self-checking bench for rcl_sched
module tb_rcl_sched;

    localparam int NREQ = 4;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*30-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              eng_in_valid;
    logic [4:0]        eng_coef_Q;
    logic [4:0]        eng_coef_L;
    logic              eng_out_valid;
    logic [1:0]        eng_out;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [1:0]        rsp_out;
    logic              busy;
    logic              err;

    rcl_sched #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .eng_in_valid(eng_in_valid), .eng_coef_Q(eng_coef_Q), .eng_coef_L(eng_coef_L),
        .eng_out_valid(eng_out_valid), .eng_out(eng_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int cyc; int a; int b; } ev_t;
    typedef struct { int due; int val; } er_t;
    typedef struct { int id; int val; } tag_t;

    int checks = 0;
    int errors = 0;

    // stimulus state
    int          cyc;
    bit          pend [NREQ];
    logic [29:0] pkt  [NREQ];
    int          p_new;
    bit          hold;
    int          eng_lat;
    int          eng_fixed;
    bit          force_eov;
    int          force_val;

    // engine model
    er_t         engq [$];
    logic [4:0]  bq [3];
    logic [4:0]  bl [3];
    int          nb;
    int          last_due;

    // reference model
    bit          have_g;
    int          last_g;
    int          rr;
    int          inflight;
    tag_t        expq [$];
    bit          pop_prev;
    tag_t        pop_ent;
    bit          err_exp;

    // history for directed checks
    ev_t         grant_h [$];
    ev_t         beat_h [$];
    ev_t         rsp_h [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stand-in for the relation engine: any deterministic function of the full packet.
    function automatic int eng_fn(input logic [29:0] w);
        longint unsigned p;
        p = 64'(w) * 64'd2654435761;
        return int'((p >> 17) % 3);
    endfunction

    task automatic model_reset();
        have_g   = 0;
        last_g   = 0;
        rr       = NREQ - 1;
        inflight = 0;
        expq.delete();
        pop_prev = 0;
        err_exp  = 0;
        engq.delete();
        nb       = 0;
        last_due = -1;
        grant_h.delete();
        beat_h.delete();
        rsp_h.delete();
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        req_valid     = '0;
        eng_out_valid = 1'b0;
        eng_out       = '0;
        force_eov     = 0;
        #1;
        chk("rst_eng_in_valid", eng_in_valid, 0);
        chk("rst_coef_Q", eng_coef_Q, 0);
        chk("rst_coef_L", eng_coef_L, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_out", rsp_out, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs at edge+1, check and model at edge+2.
    task automatic step();
        bit mp;
        bit g;
        int w;
        int exp_ready;
        int dt;
        bit in_beat;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = pend[i];
            req_data[30*i +: 30] = pkt[i];
        end
        eng_out_valid = 1'b0;
        eng_out       = '0;
        if (force_eov) begin
            eng_out_valid = 1'b1;
            eng_out       = 2'(force_val);
            force_eov     = 0;
        end else if (engq.size() > 0 && engq[0].due <= cyc && !hold) begin
            eng_out_valid = 1'b1;
            eng_out       = 2'(engq[0].val);
            void'(engq.pop_front());
        end
        #1;
        mp = eng_out_valid && inflight > 0;
        dt = cyc - last_g;
        in_beat = have_g && dt >= 1 && dt <= 3;

        chk("err", err, err_exp);
        if (eng_out_valid && inflight == 0) err_exp = 1;
        chk("busy", busy, in_beat || inflight > 0);

        g = 0;
        w = 0;
        if ((!have_g || dt >= 3) && (inflight < 2 || mp)) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (rr + k) % NREQ;
                if (!g && pend[c]) begin
                    g = 1;
                    w = c;
                end
            end
        end
        exp_ready = g ? (1 << w) : 0;
        chk("req_ready", req_ready, exp_ready);

        chk("eng_in_valid", eng_in_valid, in_beat);
        if (eng_in_valid) begin
            beat_h.push_back('{cyc, int'(eng_coef_Q), int'(eng_coef_L)});
            if (nb < 3) begin
                bq[nb] = eng_coef_Q;
                bl[nb] = eng_coef_L;
                nb++;
            end
            if (nb == 3) begin
                int due;
                int val;
                due = cyc + eng_lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                val = (eng_fixed >= 0) ? eng_fixed
                                       : eng_fn({bq[0], bl[0], bq[1], bl[1], bq[2], bl[2]});
                engq.push_back('{due, val});
                nb = 0;
            end
        end

        chk("rsp_valid", rsp_valid, pop_prev);
        if (rsp_valid) rsp_h.push_back('{cyc, int'(rsp_id), int'(rsp_out)});
        if (pop_prev && rsp_valid) begin
            chk("rsp_id", rsp_id, pop_ent.id);
            chk("rsp_out", rsp_out, pop_ent.val);
        end

        pop_prev = mp;
        if (mp) pop_ent = expq.pop_front();
        if (g) begin
            expq.push_back('{w, (eng_fixed >= 0) ? eng_fixed : eng_fn(pkt[w])});
            grant_h.push_back('{cyc, w, 0});
            have_g = 1;
            last_g = cyc;
            rr     = w;
            pend[w] = 0;
            pkt[w]  = 30'($urandom);
        end
        inflight = inflight + int'(g) - int'(mp);
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && int'($urandom_range(99)) < p_new) pend[i] = 1;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int g0;
        int rc;
        bit drained;
        cyc       = 0;
        p_new     = 0;
        hold      = 0;
        eng_lat   = 2;
        eng_fixed = -1;
        force_eov = 0;
        force_val = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        eng_out_valid = 1'b0;
        eng_out   = '0;
        for (int i = 0; i < NREQ; i++) pkt[i] = 30'($urandom);

        // single request, id 1, engine answers 1
        do_reset();
        eng_fixed = 1;
        pkt[1]  = {5'd0, 5'd1, 5'd0, 5'd0, 5'd9, 5'h1D};
        pend[1] = 1;
        repeat (10) step();
        g0 = grant_h[0].cyc;
        chk("t1_grants", grant_h.size(), 1);
        chk("t1_grant_id", grant_h[0].a, 1);
        chk("t1_beats", beat_h.size(), 3);
        chk("t1_b0_cyc", beat_h[0].cyc, g0 + 1);
        chk("t1_b0", {beat_h[0].a, beat_h[0].b}, {32'd0, 32'd1});
        chk("t1_b1", {beat_h[1].a, beat_h[1].b}, {32'd0, 32'd0});
        chk("t1_b2", {beat_h[2].a, beat_h[2].b}, {32'd9, 32'h1D});
        chk("t1_b2_cyc", beat_h[2].cyc, g0 + 3);
        chk("t1_rsp_cyc", rsp_h[0].cyc, g0 + 6);
        chk("t1_rsp", {rsp_h[0].a, rsp_h[0].b}, {32'd1, 32'd1});
        eng_fixed = -1;

        // all four pending from reset release
        do_reset();
        for (int i = 0; i < NREQ; i++) pend[i] = 1;
        repeat (24) step();
        g0 = grant_h[0].cyc;
        chk("t2_grants", grant_h.size(), 4);
        chk("t2_rsps", rsp_h.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_grant%0d", i), {grant_h[i].a, grant_h[i].cyc}, {i, g0 + 3*i});
            chk($sformatf("t2_rsp%0d", i), {rsp_h[i].a, rsp_h[i].cyc}, {i, g0 + 6 + 3*i});
        end

        // round robin: 2 first, then 0 and 3 pending -> 3 then 0
        do_reset();
        pend[2] = 1;
        step();
        pend[0] = 1;
        pend[3] = 1;
        repeat (12) step();
        chk("t3_grants", grant_h.size(), 3);
        chk("t3_order", {grant_h[0].a, grant_h[1].a, grant_h[2].a}, {32'd2, 32'd3, 32'd0});

        // engine withholds results: backpressure, then grant on the pop cycle
        do_reset();
        hold = 1;
        pend[0] = 1;
        pend[1] = 1;
        pend[2] = 1;
        repeat (12) step();
        chk("t4_grants", grant_h.size(), 2);
        chk("t4_beats", beat_h.size(), 6);
        chk("t4_ready", req_ready, 0);
        chk("t4_in_valid", eng_in_valid, 0);
        hold = 0;
        rc = cyc;
        repeat (12) step();
        chk("t4_grant3_id", grant_h[2].a, 2);
        chk("t4_grant3_cyc", grant_h[2].cyc, rc);

        // stray engine result while idle
        do_reset();
        force_eov = 1;
        force_val = 2;
        repeat (6) step();
        chk("t5_err", err, 1);
        chk("t5_no_rsp", rsp_h.size(), 0);

        // reset during B1
        do_reset();
        pend[2] = 1;
        for (int i = 0; i < 10 && grant_h.size() == 0; i++) step();
        step();
        chk("t6_in_b1", eng_in_valid, 1);
        do_reset();
        pend[0] = 1;
        pend[3] = 1;
        repeat (8) step();
        chk("t6_first", grant_h[0].a, 0);

        // randomized traffic with variable engine latency and stalls
        do_reset();
        p_new = 30;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 5) hold = !hold;
            eng_lat = int'($urandom_range(2, 6));
            step();
        end
        hold  = 0;
        p_new = 0;
        drained = 0;
        for (int i = 0; i < 300 && !drained; i++) begin
            step();
            drained = (inflight == 0) && (expq.size() == 0) && !pop_prev;
        end
        chk("drain", drained, 1);
        repeat (4) step();
        chk("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
